keypad_scanner: RTL

- Scans a 4x4 matrix keypad by driving one row low at a time and reading the four column lines.
- Debounces the full 16-key snapshot and reports single key presses as a hex code plus a one-cycle valid pulse.
- Input-side counterpart of the 4-digit multiplexed seven-segment driver. Row strobing uses the same active-low one-hot rotation as the digit enables, and key_code feeds the display's hex digit inputs directly.

---
 rtl/keypad_scanner.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: active-low one-hot row strobing, 2-flop column
// synchroniser, full-frame debounce and single-key report FSM with ghost blocking.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 4096,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_BLOCKED
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       col_meta_q, col_meta_d;
  logic [3:0]       col_sync_q, col_sync_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_q, row_d;
  logic [11:0]      frame_q, frame_d;
  logic [15:0]      prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stable_q, stable_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             down_q, down_d;

  logic [3:0]  row_sample;
  logic [15:0] done_frame;
  logic        eval;
  logic        one_hot;
  logic [3:0]  key_idx;

  always_comb begin
    col_meta_d = col_in;
    col_sync_d = col_meta_q;
  end

  // Rows 0..2 are held in frame_q; row 3 is folded in straight from the sample.
  always_comb begin
    div_d      = div_q;
    row_d      = row_q;
    frame_d    = frame_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    eval       = 1'b0;
    row_sample = ~col_sync_q;
    done_frame = {row_sample, frame_q};

    if (div_q == DIV_LAST) begin
      div_d = '0;
      row_d = row_q + 2'd1;
      case (row_q)
        2'd0: frame_d[3:0]  = row_sample;
        2'd1: frame_d[7:4]  = row_sample;
        2'd2: frame_d[11:8] = row_sample;
        default: begin
          if (done_frame == prev_q) begin
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d  = CNT_W'(1);
            prev_d = done_frame;
          end
          if (cnt_d == CNT_SAT) begin
            stable_d = done_frame;
            eval     = 1'b1;
          end
        end
      endcase
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_comb begin
    key_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (stable_d[i]) key_idx = 4'(i);
    end
    one_hot = (stable_d != '0) && ((stable_d & (stable_d - 16'd1)) == '0);
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = 1'b0;
    down_d  = down_q;

    if (eval) begin
      case (state_q)
        ST_IDLE: begin
          if (one_hot) begin
            state_d = ST_PRESSED;
            code_d  = key_idx;
            valid_d = 1'b1;
            down_d  = 1'b1;
          end else if (stable_d != '0) begin
            state_d = ST_BLOCKED;
          end
        end
        ST_PRESSED: begin
          if (stable_d == '0) begin
            state_d = ST_IDLE;
            down_d  = 1'b0;
          end else if (stable_d != stable_q) begin
            state_d = ST_BLOCKED;
            down_d  = 1'b0;
          end
        end
        ST_BLOCKED: begin
          if (stable_d == '0) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          down_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
      div_q      <= '0;
      row_q      <= '0;
      frame_q    <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      stable_q   <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      down_q     <= 1'b0;
    end else begin
      col_meta_q <= col_meta_d;
      col_sync_q <= col_sync_d;
      div_q      <= div_d;
      row_q      <= row_d;
      frame_q    <= frame_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      down_q     <= down_d;
    end
  end

  assign row_out   = ~(4'b0001 << row_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;

endmodule
